// File: rtl/bp_pkg.sv
// bp_pkg: shared types and defaults for the branch-predictor update sequencer.
//   upd_entry_t     - one queued update {pc, target, taken, is_jump}
//   bp_ctrl_state_e - sequencer states CLEAR / RUN
//   ST_CLEAR/ST_RUN - legacy-compatible constants for the state register
package bp_pkg;

    localparam int unsigned BP_QDEPTH_DEF      = 4;
    localparam int unsigned BP_CLR_ENTRIES_DEF = 64;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    typedef enum logic [0:0] {
        CLEAR = ST_CLEAR,
        RUN   = ST_RUN
    } bp_ctrl_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        is_jump;
    } upd_entry_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: small in-order queue of pending table updates.
//   clk, rst (sync, active-low)
//   push/din  - enqueue din; accepted when not full, or when full with a same-cycle pop
//   pop       - dequeue head (ignored when empty)
//   clear     - drop all entries (wins over push/pop)
//   full, empty, head - status and current head entry
module bp_upd_fifo #(
    parameter int unsigned QDEPTH = 4,
    parameter type         entry_t = logic
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    input  logic   clear,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int unsigned PW = $clog2(QDEPTH);

    entry_t        mem [QDEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(QDEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (rst && !clear && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are PW bits wide so they wrap naturally for power-of-two depths.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: sequencer for the PHT/BTB single write port.
//   Inputs : clk, rst (sync, active-low), EX resolution (is_branch_ex, is_jump_ex, stall_ex,
//            pc_ex, branch_pc_ex, cmp_out_ex), flush_req, tbl_ready
//   Outputs: upd_valid/upd_clear/upd_pht_we/upd_btb_we/upd_idx/upd_pc/upd_target/upd_taken,
//            bp_enable (IF may use predictions), drop_pulse (event lost, queue full)
//   Option : BP_UPD_STATS_EN adds stat_branches, stat_jumps, stat_drops (32-bit, wrap).
// After reset or flush every table index is cleared before predictions are re-enabled.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned QDEPTH      = BP_QDEPTH_DEF,
    parameter int unsigned CLR_ENTRIES = BP_CLR_ENTRIES_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           is_branch_ex,
    input  logic                           is_jump_ex,
    input  logic                           stall_ex,
    input  logic [31:0]                    pc_ex,
    input  logic [31:0]                    branch_pc_ex,
    input  logic                           cmp_out_ex,
    input  logic                           flush_req,
    input  logic                           tbl_ready,
    output logic                           upd_valid,
    output logic                           upd_clear,
    output logic                           upd_pht_we,
    output logic                           upd_btb_we,
    output logic [$clog2(CLR_ENTRIES)-1:0] upd_idx,
    output logic [31:0]                    upd_pc,
    output logic [31:0]                    upd_target,
    output logic                           upd_taken,
    output logic                           bp_enable,
    output logic                           drop_pulse
`ifdef BP_UPD_STATS_EN
    ,
    output logic [31:0]                    stat_branches,
    output logic [31:0]                    stat_jumps,
    output logic [31:0]                    stat_drops
`endif
);

    localparam int unsigned IW = $clog2(CLR_ENTRIES);

    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [IW-1:0] clr_idx_q;
    logic [IW-1:0] clr_idx_d;

    logic          in_run;
    logic          ev;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          drop;
    upd_entry_t    ev_entry;
    upd_entry_t    head;

    assign in_run = (state_q == ST_RUN);
    assign ev     = (is_branch_ex | is_jump_ex) & ~stall_ex;

    // A jump wins over a branch flag and is always recorded as taken.
    assign ev_entry = '{
        pc:      pc_ex,
        target:  branch_pc_ex,
        taken:   cmp_out_ex | is_jump_ex,
        is_jump: is_jump_ex
    };

    assign fifo_pop  = in_run & ~fifo_empty & tbl_ready;
    assign fifo_push = in_run & ev & ~flush_req & (~fifo_full | fifo_pop);
    // Events coinciding with a flush are discarded silently, not counted as drops.
    assign drop      = in_run & ev & ~flush_req & fifo_full & ~fifo_pop;

    bp_upd_fifo #(
        .QDEPTH  (QDEPTH),
        .entry_t (upd_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (ev_entry),
        .pop   (fifo_pop),
        .clear (flush_req),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (flush_req) begin
            state_d   = ST_CLEAR;
            clr_idx_d = '0;
        end else if (state_q == ST_CLEAR && tbl_ready) begin
            if (clr_idx_q == IW'(CLR_ENTRIES - 1)) begin
                state_d   = ST_RUN;
                clr_idx_d = '0;
            end else begin
                clr_idx_d = clr_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Every output is forced low while reset is asserted.
    always_comb begin
        upd_valid  = 1'b0;
        upd_clear  = 1'b0;
        upd_pht_we = 1'b0;
        upd_btb_we = 1'b0;
        upd_idx    = '0;
        upd_pc     = '0;
        upd_target = '0;
        upd_taken  = 1'b0;
        bp_enable  = 1'b0;
        drop_pulse = 1'b0;
        if (rst) begin
            if (!in_run) begin
                upd_valid  = 1'b1;
                upd_clear  = 1'b1;
                upd_pht_we = 1'b1;
                upd_btb_we = 1'b1;
                upd_idx    = clr_idx_q;
            end else begin
                bp_enable  = 1'b1;
                drop_pulse = drop;
                if (!fifo_empty) begin
                    upd_valid  = 1'b1;
                    upd_pht_we = ~head.is_jump;
                    upd_btb_we = head.is_jump | head.taken;
                    upd_pc     = head.pc;
                    upd_target = head.target;
                    upd_taken  = head.taken;
                end
            end
        end
    end

`ifdef BP_UPD_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_jp_q;
    logic [31:0] stat_dr_q;

    // Cleared by reset only; a flush leaves the counts intact.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_br_q <= '0;
            stat_jp_q <= '0;
            stat_dr_q <= '0;
        end else begin
            if (fifo_push && !ev_entry.is_jump) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (fifo_push && ev_entry.is_jump) begin
                stat_jp_q <= stat_jp_q + 32'd1;
            end
            if (drop) begin
                stat_dr_q <= stat_dr_q + 32'd1;
            end
        end
    end

    assign stat_branches = rst ? stat_br_q : '0;
    assign stat_jumps    = rst ? stat_jp_q : '0;
    assign stat_drops    = rst ? stat_dr_q : '0;
`endif

endmodule
